// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stage enables, flushes and PC redirect,
// with a data-memory wait FSM, timeout halt and perf counters.
module pipe_hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             brench,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WC_W = $clog2(TIMEOUT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    HALT
  } state_t;

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wait_q, wait_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             flush_ev;
  logic             hazard;

  // Load-use: a load in EX feeding a live source of the ID instruction.
  assign hazard = ex_mem_read && (ex_rd != '0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd)));

  // Control decode and FSM next state, in priority order per state.
  always_comb begin
    pc_en       = 1'b0;
    pc_sel      = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    flush_ev    = 1'b0;
    state_d     = state_q;
    wait_d      = wait_q;
    halted_d    = halted_q;
    unique case (state_q)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          state_d = MEM_WAIT;
          wait_d  = WC_W'(1);
        end else if (brench) begin
          pc_en       = 1'b1;
          pc_sel      = 1'b1;
          if_id_en    = 1'b1;
          id_ex_en    = 1'b1;
          ex_mem_en   = 1'b1;
          mem_wb_en   = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_ev    = 1'b1;
        end else if (hazard) begin
          id_ex_en    = 1'b1;
          ex_mem_en   = 1'b1;
          mem_wb_en   = 1'b1;
          id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
          if_id_en    = 1'b1;
          id_ex_en    = 1'b1;
          ex_mem_en   = 1'b1;
          mem_wb_en   = 1'b1;
          if_id_flush = 1'b1;
        end else begin
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          mem_wb_en = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          mem_wb_en = 1'b1;
          state_d   = RUN;
          wait_d    = '0;
        end else if (wait_q == WC_LAST) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else begin
          wait_d = wait_q + WC_W'(1);
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Saturating counters; frozen while halted.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (state_q != HALT && !pc_en && stall_q != '1)
      stall_d = stall_q + CNT_W'(1);
    if (flush_ev && flush_q != '1)
      flush_d = flush_q + CNT_W'(1);
  end

  // State, wait counter, sticky halt and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      wait_q   <= '0;
      halted_q <= 1'b0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      halted_q <= halted_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end

  assign halted    = halted_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (TIMEOUT=4, CNT_W=4).
// Control bundle order: pc_en,pc_sel,if_id_en,id_ex_en,ex_mem_en,mem_wb_en,if_id_flush,id_ex_flush.
module tb_pipe_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  localparam logic [7:0] C_RUN  = 8'b1011_1100;
  localparam logic [7:0] C_BR   = 8'b1111_1111;
  localparam logic [7:0] C_LU   = 8'b0001_1101;
  localparam logic [7:0] C_IMEM = 8'b0011_1110;
  localparam logic [7:0] C_OFF  = 8'b0000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             brench;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rd;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_en;
  logic             pc_sel;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_W  (REG_W),
    .TIMEOUT(4),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .brench     (brench),
    .ex_mem_read(ex_mem_read),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .imem_ready (imem_ready),
    .dmem_req   (dmem_req),
    .dmem_ready (dmem_ready),
    .pc_en      (pc_en),
    .pc_sel     (pc_sel),
    .if_id_en   (if_id_en),
    .id_ex_en   (id_ex_en),
    .ex_mem_en  (ex_mem_en),
    .mem_wb_en  (mem_wb_en),
    .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush),
    .halted     (halted),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  wire [7:0] ctrl = {pc_en, pc_sel, if_id_en, id_ex_en,
                     ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input logic h,
                          input int st, input int fl);
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, h});
    chk({tag, ".stall"}, {28'd0, stall_cnt}, st);
    chk({tag, ".flush"}, {28'd0, flush_cnt}, fl);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    brench      = 1'b0;
    ex_mem_read = 1'b0;
    ex_rd       = '0;
    id_rs1      = '0;
    id_rs2      = '0;
    id_use_rs1  = 1'b0;
    id_use_rs2  = 1'b0;
    imem_ready  = 1'b1;
    dmem_req    = 1'b0;
    dmem_ready  = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #2;
    chk("rst.ctrl", {24'd0, ctrl}, {24'd0, C_RUN});
    chk_regs("rst", 1'b0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Idle run
    #1 chk("idle.ctrl", {24'd0, ctrl}, {24'd0, C_RUN});
    step();
    chk_regs("idle", 1'b0, 0, 0);

    // Branch wins over missing fetch
    brench = 1'b1;
    imem_ready = 1'b0;
    #1 chk("br.ctrl", {24'd0, ctrl}, {24'd0, C_BR});
    step();
    chk_regs("br", 1'b0, 0, 1);
    brench = 1'b0;

    // Fetch not ready
    #1 chk("imem.ctrl", {24'd0, ctrl}, {24'd0, C_IMEM});
    step();
    chk_regs("imem", 1'b0, 1, 1);
    imem_ready = 1'b1;

    // Load-use on rs2
    ex_mem_read = 1'b1;
    ex_rd = 5'd5;
    id_rs2 = 5'd5;
    id_use_rs2 = 1'b1;
    #1 chk("lu2.ctrl", {24'd0, ctrl}, {24'd0, C_LU});
    step();
    chk_regs("lu2", 1'b0, 2, 1);

    // x0 destination never stalls
    ex_rd = 5'd0;
    id_rs2 = 5'd0;
    #1 chk("lu0.ctrl", {24'd0, ctrl}, {24'd0, C_RUN});
    step();
    chk_regs("lu0", 1'b0, 2, 1);

    // rs1 matches but unused, then used
    ex_rd = 5'd7;
    id_rs1 = 5'd7;
    id_rs2 = 5'd3;
    #1 chk("lu1off.ctrl", {24'd0, ctrl}, {24'd0, C_RUN});
    id_use_rs1 = 1'b1;
    #1 chk("lu1.ctrl", {24'd0, ctrl}, {24'd0, C_LU});
    step();
    chk_regs("lu1", 1'b0, 3, 1);
    idle();

    // Memory wait with branch held in EX
    brench = 1'b1;
    dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("mw%0d.ctrl", i), {24'd0, ctrl}, {24'd0, C_OFF});
      step();
    end
    chk_regs("mw", 1'b0, 6, 1);
    dmem_ready = 1'b1;
    #1 chk("mwdone.ctrl", {24'd0, ctrl}, {24'd0, C_RUN});
    step();
    chk_regs("mwdone", 1'b0, 6, 1);
    dmem_req = 1'b0;
    dmem_ready = 1'b0;
    #1 chk("mwbr.ctrl", {24'd0, ctrl}, {24'd0, C_BR});
    step();
    chk_regs("mwbr", 1'b0, 6, 2);
    idle();

    // Timeout into HALT
    dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("to%0d.halted", i), {31'd0, halted}, 32'd0);
    end
    step();
    chk_regs("to", 1'b1, 10, 2);
    brench = 1'b1;
    dmem_ready = 1'b1;
    #1 chk("halt.ctrl", {24'd0, ctrl}, {24'd0, C_OFF});
    step();
    chk_regs("halt", 1'b1, 10, 2);

    // Asynchronous reset out of HALT
    #2 rst = 1'b1;
    #1;
    chk_regs("arst", 1'b0, 0, 0);
    chk("arst.ctrl", {24'd0, ctrl}, {24'd0, C_BR});
    @(posedge clk);
    #1 rst = 1'b0;
    idle();

    // Stall counter saturation
    ex_mem_read = 1'b1;
    ex_rd = 5'd9;
    id_rs1 = 5'd9;
    id_use_rs1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 13)
        chk("sat14", {28'd0, stall_cnt}, 32'd14);
    end
    chk("sat.ctrl", {24'd0, ctrl}, {24'd0, C_LU});
    chk_regs("sat", 1'b0, 15, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
